// File: rtl/mc_sequencer_if.sv
// Interface bundling the sequencer's control inputs, phase enables and counters.
// The sequencer uses the master modport; the decoder/memory side uses slave.
interface mc_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic             halt_req;
  logic             im_ready;
  logic             dm_ready;
  logic             need_mem;
  logic             need_wb;
  logic             enable_fetch;
  logic             enable_decode;
  logic             enable_execute;
  logic             enable_memaccess;
  logic             enable_writeback;
  logic             instr_latch;
  logic             retire;
  logic             busy;
  logic             timeout_err;
  logic [CNT_W-1:0] retired_count;
  logic [CNT_W-1:0] stall_count;
  logic [2:0]       dbg_state;

  // Handshakes: a fetch completes in a cycle where enable_fetch and im_ready are
  // both high, a data access where enable_memaccess and dm_ready are both high.
  // A ready seen while its phase enable is low has no effect.
  modport master (
    input  run, halt_req, im_ready, dm_ready, need_mem, need_wb,
    output enable_fetch, enable_decode, enable_execute, enable_memaccess,
    output enable_writeback, instr_latch, retire, busy, timeout_err,
    output retired_count, stall_count, dbg_state
  );

  modport slave (
    output run, halt_req, im_ready, dm_ready, need_mem, need_wb,
    input  enable_fetch, enable_decode, enable_execute, enable_memaccess,
    input  enable_writeback, instr_latch, retire, busy, timeout_err,
    input  retired_count, stall_count, dbg_state
  );
endinterface

// File: rtl/mc_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with phase skipping,
// ready stalls, wait timeout and retire counter. Define SEQ_STALL_CNT_EN for stall_count.
module mc_sequencer #(
  parameter int EXEC_CYCLES = 1,
  parameter int TIMEOUT     = 255,
  parameter int TO_W        = 8,
  parameter int CNT_W       = 16
) (
  input  logic          clock,
  input  logic          reset,
  mc_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERROR  = 3'd6
  } state_e;

  localparam logic [3:0]      EXEC_LAST = 4'(EXEC_CYCLES - 1);
  localparam logic [TO_W-1:0] TIMEOUT_V = TO_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic [3:0]       exec_cnt_q, exec_cnt_d;
  logic [TO_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire_w;
  logic             latch_w;
  logic             wait_expired;

  assign wait_expired = (TIMEOUT != 0) && (wait_q == TIMEOUT_V);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      exec_cnt_q <= '0;
      wait_q     <= '0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      exec_cnt_q <= exec_cnt_d;
      wait_q     <= wait_d;
      retired_q  <= retired_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    exec_cnt_d = exec_cnt_q;
    wait_d     = wait_q;
    retired_d  = retired_q;
    retire_w   = 1'b0;
    latch_w    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.run) state_d = S_FETCH;
      end
      S_FETCH: begin
        // Ready wins over an expiring wait counter in the same cycle.
        if (bus.im_ready) begin
          latch_w = 1'b1;
          wait_d  = '0;
          state_d = S_DECODE;
        end else if (wait_expired) begin
          state_d = S_ERROR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: begin
        exec_cnt_d = '0;
        state_d    = S_EXEC;
      end
      S_EXEC: begin
        if (exec_cnt_q == EXEC_LAST) begin
          if (bus.need_mem)     state_d  = S_MEM;
          else if (bus.need_wb) state_d  = S_WB;
          else                  retire_w = 1'b1;
        end else begin
          exec_cnt_d = exec_cnt_q + 1'b1;
        end
      end
      S_MEM: begin
        if (bus.dm_ready) begin
          wait_d = '0;
          if (bus.need_wb) state_d  = S_WB;
          else             retire_w = 1'b1;
        end else if (wait_expired) begin
          state_d = S_ERROR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB:    retire_w = 1'b1;
      S_ERROR: state_d  = S_ERROR;
      default: state_d  = S_IDLE;
    endcase
    // halt_req and run only decide the follow-on state in the retire cycle.
    if (retire_w) begin
      retired_d = retired_q + 1'b1;
      state_d   = (bus.run && !bus.halt_req) ? S_FETCH : S_IDLE;
    end
  end

  assign bus.enable_fetch     = (state_q == S_FETCH);
  assign bus.enable_decode    = (state_q == S_DECODE);
  assign bus.enable_execute   = (state_q == S_EXEC);
  assign bus.enable_memaccess = (state_q == S_MEM);
  assign bus.enable_writeback = (state_q == S_WB);
  assign bus.busy             = (state_q != S_IDLE) && (state_q != S_ERROR);
  assign bus.timeout_err      = (state_q == S_ERROR);
  assign bus.instr_latch      = latch_w;
  assign bus.retire           = retire_w;
  assign bus.retired_count    = retired_q;
  assign bus.dbg_state        = state_q;

`ifdef SEQ_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic             stalling;

  assign stalling = ((state_q == S_FETCH) && !bus.im_ready) ||
                    ((state_q == S_MEM)   && !bus.dm_ready);

  // Saturates rather than wrapping so a long-running count never looks small.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                           stall_q <= '0;
    else if (stalling && (stall_q != '1)) stall_q <= stall_q + 1'b1;
  end

  assign bus.stall_count = stall_q;
`else
  assign bus.stall_count = '0;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Randomized bench for mc_sequencer: two instances (EXEC_CYCLES 1 and 2, TIMEOUT 4)
// checked cycle by cycle against an instruction-level phase model.
module tb_mc_sequencer;

  localparam int EXEC0 = 1;
  localparam int EXEC1 = 2;
  localparam int TMO   = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mc_sequencer_if #(.CNT_W(16)) bus0 ();
  mc_sequencer_if #(.CNT_W(16)) bus1 ();

  mc_sequencer #(.EXEC_CYCLES(EXEC0), .TIMEOUT(TMO), .TO_W(8), .CNT_W(16)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0)
  );
  mc_sequencer #(.EXEC_CYCLES(EXEC1), .TIMEOUT(TMO), .TO_W(8), .CNT_W(16)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1)
  );

  // stimulus word: {run, halt_req, im_ready, dm_ready, need_mem, need_wb}
  logic [5:0] in_r [2];
  initial begin
    in_r[0] = '0;
    in_r[1] = '0;
  end

  assign bus0.run = in_r[0][5]; assign bus0.halt_req = in_r[0][4];
  assign bus0.im_ready = in_r[0][3]; assign bus0.dm_ready = in_r[0][2];
  assign bus0.need_mem = in_r[0][1]; assign bus0.need_wb = in_r[0][0];
  assign bus1.run = in_r[1][5]; assign bus1.halt_req = in_r[1][4];
  assign bus1.im_ready = in_r[1][3]; assign bus1.dm_ready = in_r[1][2];
  assign bus1.need_mem = in_r[1][1]; assign bus1.need_wb = in_r[1][0];

  logic [4:0]  en_o [2];
  logic        latch_o [2], retire_o [2], busy_o [2], terr_o [2];
  logic [15:0] rcnt_o [2], scnt_o [2];

  assign en_o[0] = {bus0.enable_writeback, bus0.enable_memaccess, bus0.enable_execute,
                    bus0.enable_decode, bus0.enable_fetch};
  assign en_o[1] = {bus1.enable_writeback, bus1.enable_memaccess, bus1.enable_execute,
                    bus1.enable_decode, bus1.enable_fetch};
  assign latch_o[0] = bus0.instr_latch; assign latch_o[1] = bus1.instr_latch;
  assign retire_o[0] = bus0.retire;     assign retire_o[1] = bus1.retire;
  assign busy_o[0] = bus0.busy;         assign busy_o[1] = bus1.busy;
  assign terr_o[0] = bus0.timeout_err;  assign terr_o[1] = bus1.timeout_err;
  assign rcnt_o[0] = bus0.retired_count; assign rcnt_o[1] = bus1.retired_count;
  assign scnt_o[0] = bus0.stall_count;   assign scnt_o[1] = bus1.stall_count;

  // Model state. Phase codes: 0 none, 1 F, 2 D, 3 E, 4 M, 5 W.
  // exp word: {phase[2:0], instr_latch, retire, busy}
  logic [5:0]  stim_q [$];
  logic [5:0]  exp_q [$];
  logic [15:0] exp_retired [2];
  logic [15:0] exp_stall [2];
  logic        idle_m [2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [15:0] stall_exp(input int d);
`ifdef SEQ_STALL_CNT_EN
    return exp_stall[d];
`else
    return (d > 1) ? exp_stall[0] : 16'd0;
`endif
  endfunction

  task automatic model_clear();
    stim_q.delete();
    exp_q.delete();
    for (int d = 0; d < 2; d++) begin
      exp_retired[d] = '0;
      exp_stall[d]   = '0;
      idle_m[d]      = 1'b1;
    end
  endtask

  task automatic push(input logic [5:0] s, input logic [2:0] code,
                      input logic latch, input logic ret, input logic bsy);
    stim_q.push_back(s);
    exp_q.push_back({code, latch, ret, bsy});
  endtask

  task automatic push_idle(input int n);
    for (int k = 0; k < n; k++) push({1'b0, rb(), rb(), rb(), rb(), rb()}, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // stop: 0 continue with next fetch, 1 halt_req at retire, 2 run low at retire
  task automatic build_instr(input int d, input int fw, input logic mem, input logic wb,
                             input int mw, input int stop);
    int   ec;
    logic ret, rn, hl;
    ec = (d == 0) ? EXEC0 : EXEC1;
    if (stop == 0)      begin rn = 1'b1; hl = 1'b0; end
    else if (stop == 1) begin rn = 1'b1; hl = 1'b1; end
    else                begin rn = 1'b0; hl = rb(); end
    if (idle_m[d]) push({1'b1, rb(), rb(), rb(), rb(), rb()}, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k <= fw; k++)
      push({rb(), rb(), 1'(k == fw), rb(), rb(), rb()}, 3'd1, 1'(k == fw), 1'b0, 1'b1);
    push({rb(), rb(), rb(), rb(), rb(), rb()}, 3'd2, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < ec; k++) begin
      ret = (k == ec - 1) && !mem && !wb;
      push({ret ? rn : rb(), ret ? hl : rb(), rb(), rb(), mem, wb}, 3'd3, 1'b0, ret, 1'b1);
    end
    if (mem) begin
      for (int k = 0; k <= mw; k++) begin
        ret = (k == mw) && !wb;
        push({ret ? rn : rb(), ret ? hl : rb(), rb(), 1'(k == mw), mem, wb}, 3'd4, 1'b0, ret, 1'b1);
      end
    end
    if (wb) push({rn, hl, rb(), rb(), mem, wb}, 3'd5, 1'b0, 1'b1, 1'b1);
    idle_m[d] = (stop != 0);
  endtask

  task automatic drive_q(input int d, input int max_n);
    int         n;
    logic [5:0] s, e;
    logic [4:0] een;
    n = 0;
    while (stim_q.size() > 0 && n < max_n) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clock);
      in_r[d] = s;
      #1;
      een = (e[5:3] == 3'd0) ? 5'd0 : 5'(1 << (int'(e[5:3]) - 1));
      check_eq($sformatf("d%0d enables", d), en_o[d], een);
      check_eq($sformatf("d%0d instr_latch", d), latch_o[d], e[2]);
      check_eq($sformatf("d%0d retire", d), retire_o[d], e[1]);
      check_eq($sformatf("d%0d busy", d), busy_o[d], e[0]);
      check_eq($sformatf("d%0d timeout_err", d), terr_o[d], 1'b0);
      check_eq($sformatf("d%0d retired_count", d), rcnt_o[d], exp_retired[d]);
      check_eq($sformatf("d%0d stall_count", d), scnt_o[d], stall_exp(d));
      if (e[1]) exp_retired[d] = exp_retired[d] + 16'd1;
      if (((e[5:3] == 3'd1) && !s[3]) || ((e[5:3] == 3'd4) && !s[2]))
        if (exp_stall[d] != 16'hffff) exp_stall[d] = exp_stall[d] + 16'd1;
      n++;
    end
  endtask

  task automatic check_all_zero(input int d, input string tag);
    check_eq($sformatf("d%0d %s outputs", d, tag),
             {en_o[d], latch_o[d], retire_o[d], busy_o[d], terr_o[d]}, 9'd0);
    check_eq($sformatf("d%0d %s retired_count", d, tag), rcnt_o[d], 16'd0);
    check_eq($sformatf("d%0d %s stall_count", d, tag), scnt_o[d], 16'd0);
  endtask

  task automatic check_idle(input int d, input string tag, input logic [15:0] rc,
                            input logic [15:0] sc);
    @(negedge clock);
    in_r[d] = '0;
    #1;
    check_eq($sformatf("d%0d %s enables", d, tag), en_o[d], 5'd0);
    check_eq($sformatf("d%0d %s busy", d, tag), busy_o[d], 1'b0);
    check_eq($sformatf("d%0d %s timeout_err", d, tag), terr_o[d], 1'b0);
    check_eq($sformatf("d%0d %s retired_count", d, tag), rcnt_o[d], rc);
    check_eq($sformatf("d%0d %s stall_count", d, tag), scnt_o[d], sc);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset   = 1'b1;
    in_r[0] = '0;
    in_r[1] = '0;
    #1;
    check_all_zero(0, "reset");
    check_all_zero(1, "reset");
    @(negedge clock);
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stop, fw, mw;
    model_clear();
    repeat (2) @(negedge clock);

    // Reset in the middle of a stalled MEM phase
    do_reset();
    build_instr(0, 0, 1'b0, 1'b1, 0, 0);
    build_instr(0, 0, 1'b1, 1'b1, 3, 1);
    drive_q(0, 9);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero(0, "rst_mid_mem");
    stim_q.delete();
    exp_q.delete();
    @(negedge clock);
    in_r[0] = '0;
    reset   = 1'b0;
    model_clear();
    check_idle(0, "after_rst", 16'd0, 16'd0);

    // Three back-to-back ALU instructions, 4 cycles each
    do_reset();
    build_instr(0, 0, 1'b0, 1'b1, 0, 0);
    build_instr(0, 0, 1'b0, 1'b1, 0, 0);
    build_instr(0, 0, 1'b0, 1'b1, 0, 2);
    drive_q(0, 100);
    check_idle(0, "alu3", 16'd3, 16'd0);

    // Load then store with two MEM wait cycles each, EXEC_CYCLES=2
    do_reset();
    build_instr(1, 0, 1'b1, 1'b1, 2, 0);
    build_instr(1, 0, 1'b1, 1'b0, 2, 1);
    check_eq("ld_st cycle budget", 32'(stim_q.size()), 32'(1 + 8 + 7));
    drive_q(1, 100);
`ifdef SEQ_STALL_CNT_EN
    check_idle(1, "ld_st", 16'd2, 16'd4);
`else
    check_idle(1, "ld_st", 16'd2, 16'd0);
`endif

    // Branch with halt_req in its EXEC cycle
    do_reset();
    build_instr(0, 0, 1'b0, 1'b0, 0, 1);
    drive_q(0, 100);
    check_idle(0, "branch_halt", 16'd1, 16'd0);

    // Ready arriving exactly when the wait counter reaches TIMEOUT
    build_instr(0, TMO, 1'b0, 1'b1, 0, 1);
    drive_q(0, 100);
    check_idle(0, "ready_at_limit", 16'd2, stall_exp(0));

    // Fetch timeout: five FETCH cycles, then ERROR until reset
    do_reset();
    push({1'b1, 5'b00000}, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k <= TMO; k++) push({1'b1, rb(), 1'b0, rb(), rb(), rb()}, 3'd1, 1'b0, 1'b0, 1'b1);
    drive_q(0, 100);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      in_r[0] = 6'b101100;
      #1;
      check_eq("d0 err enables", en_o[0], 5'd0);
      check_eq("d0 err busy", busy_o[0], 1'b0);
      check_eq("d0 err timeout_err", terr_o[0], 1'b1);
      check_eq("d0 err latch", latch_o[0], 1'b0);
      check_eq("d0 err stall_count", scnt_o[0], stall_exp(0));
    end
    do_reset();
    check_idle(0, "post_err", 16'd0, 16'd0);

    // Random instruction streams on both instances
    for (int d = 0; d < 2; d++) begin
      do_reset();
      for (int i = 0; i < 40; i++) begin
        stop = (i == 39) ? 1 : (($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
        fw   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, TMO) : 0;
        mw   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, TMO) : 0;
        if (idle_m[d]) push_idle($urandom_range(0, 2));
        build_instr(d, fw, rb(), rb(), mw, stop);
        drive_q(d, 1000);
      end
      check_idle(d, "random_end", exp_retired[d], stall_exp(d));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
